// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the multi-cycle memory access unit: access sizes,
// fault codes, FSM states and the alignment rule.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_BUS      = 2'd2,
        FLT_TIMEOUT  = 2'd3
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // DOUBLE has no legal alignment on a 32-bit datapath.
    function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                           input logic [1:0] size,
                                           input int         xlen);
        logic mis;
        mis = 1'b0;
        case (size)
            HALF:    mis = addr_lo[0];
            WORD:    mis = |addr_lo[1:0];
            DOUBLE:  mis = (xlen == 32) || (|addr_lo);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Moves the addressed lane of a full-width read word down to bit 0 and
// sign- or zero-extends it to XLEN according to the access size.
module mem_load_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [OFFW-1:0] off,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] top_bit;
    logic            fill;
    int unsigned     width;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        width   = 32'd8 << size;
        if (width > XLEN) begin
            width = XLEN;
        end
        mask    = {XLEN{1'b1}} >> (XLEN - width);
        top_bit = {{(XLEN-1){1'b0}}, 1'b1} << (width - 1);
        fill    = sign_ext && ((shifted & top_bit) != '0);
        data    = fill ? (shifted | ~mask) : (shifted & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: one access per request handshake, drives a
// req/ack data-memory port and returns extended load data plus a fault code.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic              req_store,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_err,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]        resp_fault_q, resp_fault_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [NB-1:0]     mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic              store_q, store_d;

    logic [OFFW-1:0]   req_off;
    logic [NB-1:0]     size_mask;
    logic              misaligned;
    logic [XLEN-1:0]   load_data;

    mem_load_align #(.XLEN(XLEN), .OFFW(OFFW)) u_align (
        .rdata    (mem_rdata),
        .off      (off_q),
        .size     (size_q),
        .sign_ext (sign_q),
        .data     (load_data)
    );

    always_comb begin
        req_off    = req_addr[OFFW-1:0];
        misaligned = is_misaligned(req_addr[2:0], req_size, XLEN);
        case (req_size)
            BYTE:    size_mask = NB'(1);
            HALF:    size_mask = NB'(3);
            WORD:    size_mask = NB'(15);
            default: size_mask = NB'(255);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        size_d       = size_q;
        sign_d       = sign_q;
        store_d      = store_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = FLT_MISALIGN;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = ST_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_store;
                        mem_addr_d  = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        mem_wstrb_d = req_store ? (size_mask << req_off) : '0;
                        mem_wdata_d = req_wdata << {req_off, 3'b000};
                        cnt_d       = '0;
                        off_d       = req_off;
                        size_d      = req_size;
                        sign_d      = req_signed;
                        store_d     = req_store;
                    end
                end
            end
            ST_WAIT: begin
                // An ack arriving in the expiry cycle still completes normally.
                if (mem_ack) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_fault_d = mem_err ? FLT_BUS : FLT_NONE;
                    resp_rdata_d = (mem_err || store_q) ? '0 : load_data;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_fault_d = FLT_TIMEOUT;
                    resp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (state_d == ST_RESP) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = '0;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_fault_d = FLT_NONE;
                    resp_rdata_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= FLT_NONE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
            cnt_q        <= '0;
            off_q        <= '0;
            size_q       <= '0;
            sign_q       <= 1'b0;
            store_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            store_q      <= store_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (XLEN=32, TIMEOUT=4): directed cases plus random
// accesses checked against an arithmetic model of the access rules.
module tb_mem_access_unit;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        req_store;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_store  (req_store),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_err    (mem_err),
        .mem_rdata  (mem_rdata)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model
    function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] size);
        int bytes;
        bytes = 1 << size;
        if (bytes > XLEN / 8) return 1'b1;
        return (addr % bytes) != 0;
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] addr, input logic [1:0] size,
                                              input bit store);
        int bytes;
        int m;
        if (!store) return 4'h0;
        bytes = 1 << size;
        m = ((1 << bytes) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [1:0] size, input bit sgn);
        longint v;
        longint lim;
        int bits;
        v    = longint'(rdata) >> (8 * (addr % 4));
        bits = 8 * (1 << size);
        if (bits < 32) begin
            lim = longint'(1) << bits;
            v   = v % lim;
            if (sgn && (v >= lim / 2)) v = v - lim;
        end
        return v[31:0];
    endfunction

    // driver
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input bit sgn, input bit store,
                             input int ack_at, input bit err, input logic [31:0] rdata,
                             input int hold);
        bit          mis;
        int          n_wait;
        logic [1:0]  exp_fault;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [31:0] exp_addr;

        mis      = model_misaligned(addr, size);
        exp_wd   = wdata << (8 * (addr % 4));
        exp_addr = addr & ~32'h3;
        n_wait   = 0;
        if (mis) begin
            exp_fault = 2'd1;
            exp_rd    = '0;
        end else if (ack_at >= 0 && ack_at < TO) begin
            exp_fault = err ? 2'd2 : 2'd0;
            exp_rd    = (err || store) ? 32'h0 : model_load(rdata, addr, size, sgn);
            n_wait    = ack_at + 1;
        end else begin
            exp_fault = 2'd3;
            exp_rd    = '0;
            n_wait    = TO;
        end
        exp_q.push_back({30'h0, exp_fault});
        exp_q.push_back(exp_rd);

        check("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
        req_store  = store;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;

        if (mis) begin
            check("mis_no_mem_req", mem_req, 0);
            check("mis_resp_n1", resp_valid, 1);
        end else begin
            check("resp_not_yet", resp_valid, 0);
            check("req_ready_busy", req_ready, 0);
            check("mem_we", mem_we, store);
            check("mem_wstrb", mem_wstrb, model_strb(addr, size, store));
            check("mem_wdata", mem_wdata, exp_wd);
            for (int k = 0; k < n_wait; k++) begin
                check("mem_req_wait", mem_req, 1);
                check("mem_addr", mem_addr, exp_addr);
                mem_ack   = (k == ack_at);
                mem_err   = err;
                mem_rdata = rdata;
                @(negedge clk);
            end
            mem_ack   = 1'b0;
            mem_err   = 1'b0;
            mem_rdata = $urandom;
            check("mem_req_dropped", mem_req, 0);
            check("resp_valid", resp_valid, 1);
        end

        exp_fault = exp_q.pop_front()[1:0];
        exp_rd    = exp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            check("resp_valid_hold", resp_valid, 1);
            check("resp_fault", resp_fault, exp_fault);
            check("resp_rdata", resp_rdata, exp_rd);
            check("req_ready_resp", req_ready, 0);
            resp_ready = (h == hold);
            @(negedge clk);
        end
        resp_ready = 1'b0;
        check("resp_valid_clr", resp_valid, 0);
        check("resp_fault_clr", resp_fault, 0);
        check("req_ready_back", req_ready, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_rdata"}, resp_rdata, 0);
        check({tag, "_resp_fault"}, resp_fault, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wstrb"}, mem_wstrb, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_size   = '0;
        req_signed = 1'b0;
        req_store  = 1'b0;
        resp_ready = 1'b0;
        mem_ack    = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // directed cases
        do_access(32'h1003, 32'h0, 2'd0, 1, 0, 0, 0, 32'h80FF_1234, 0);
        do_access(32'h2002, 32'h0000_BEEF, 2'd1, 0, 1, 0, 0, 32'h0, 0);
        do_access(32'h3001, 32'h0, 2'd2, 0, 0, 0, 0, 32'h0, 0);
        do_access(32'h4000, 32'h0, 2'd3, 0, 0, 0, 0, 32'h0, 0);
        do_access(32'h5000, 32'h0, 2'd2, 0, 0, -1, 0, 32'h0, 0);
        do_access(32'h5004, 32'h0, 2'd2, 0, 0, TO - 1, 0, 32'hCAFE_F00D, 0);
        do_access(32'h6002, 32'h0, 2'd1, 1, 0, 0, 1, 32'hFFFF_FFFF, 3);
        do_access(32'h7001, 32'h0, 2'd0, 0, 0, 1, 0, 32'h0000_9A00, 1);

        // stray ack while idle must not produce a response
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_resp", resp_valid, 0);
        check("idle_ack_mem_req", mem_req, 0);

        // reset in the middle of a wait, then a late ack
        req_valid = 1'b1;
        req_addr  = 32'h8000;
        req_size  = 2'd2;
        req_store = 1'b1;
        req_wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_mem_req", mem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_resp", resp_valid, 0);
        check("late_ack_ready", req_ready, 1);
        @(negedge clk);
        check("late_ack_resp2", resp_valid, 0);

        // random accesses
        for (int t = 0; t < 150; t++) begin
            a  = $urandom_range(0, 16'hFFFF);
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 1);
            do_access(a, $urandom, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 5) - 1, ($urandom_range(0, 7) == 0), $urandom,
                      $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
